pmem_arbiter: RTL and testbench
===============================

// Module: pmem_arbiter
// PURPOSE
// - Shares the single 256-bit physical-memory port between the I-cache and D-cache line-fill/writeback ports.
// - Sits between both cache pmem_* interfaces and main memory.
// - Registered request latch plus 4-state FSM; one memory transaction in flight at a time.
// PARAMETERS
// - ADDR_W  32   width of all line addresses
// - LINE_W  256  cache line / memory data width
// PORTS
// - clk           in   1       system clock
// - rst_n         in   1       synchronous reset, active-low
// - i_pmem_read   in   1       I-cache line-read request (level, held until i_pmem_resp)
// - i_pmem_addr   in   ADDR_W  I-cache line address
// - i_pmem_rdata  out  LINE_W  line returned to I-cache
// - i_pmem_resp   out  1       I-cache completion pulse
// - d_pmem_read   in   1       D-cache line-read request (level)
// - d_pmem_write  in   1       D-cache writeback request (level)
// - d_pmem_addr   in   ADDR_W  D-cache line address
// - d_pmem_wdata  in   LINE_W  D-cache writeback line
// - d_pmem_rdata  out  LINE_W  line returned to D-cache
// - d_pmem_resp   out  1       D-cache completion pulse
// - mem_read      out  1       memory read strobe
// - mem_write     out  1       memory write strobe
// - mem_addr      out  ADDR_W  memory address, registered
// - mem_wdata     out  LINE_W  memory write data, registered
// - mem_rdata     in   LINE_W  memory read data, valid when mem_resp=1
// - mem_resp      in   1       memory completion, one cycle
// BEHAVIOUR
// - Reset (rst_n=0 at posedge):
//   - state=IDLE; all outputs 0, including rdata buses and resp pulses.
//   - Round-robin pointer = I-cache.
// - Reset mid-transaction: the transaction is abandoned; memory strobes drop the next cycle and no resp is issued.
// - States: IDLE, I_BUSY, D_BUSY, RESP.
// - IDLE: grant is chosen when a request is seen; at the next edge the arbiter
//   - latches address, wdata and op;
//   - asserts mem_read or mem_write;
//   - enters I_BUSY or D_BUSY.
// - I_BUSY / D_BUSY:
//   - mem_* outputs are held stable from the latch; live cache inputs are ignored.
//   - On mem_resp=1: latch mem_rdata into the granted requester's rdata register, clear strobes, go to RESP.
// - RESP: pulse the granted requester's resp for exactly one cycle, then return to IDLE.
//   - rdata stays valid until that requester's next grant.
// - Latency: request seen in cycle N -> strobe in N+1; mem_resp in cycle M -> requester resp in M+1.
//   - Minimum round trip is 3 cycles when mem_resp arrives in N+1.
// - No re-grant in the RESP cycle: a requester still holding its request during RESP is not double-served.
// - Simultaneous requests in IDLE: the grant rule is set by CONFIGURATION below.
//   - The loser keeps its request asserted and is served in the next IDLE window.
// - d_pmem_read and d_pmem_write both high: treated as a write. This is a protocol error; a bench assertion flags it.
// - mem_read and mem_write are never both 1; neither resp output is ever 1 in the same cycle as the other.
// - mem_resp outside I_BUSY/D_BUSY is ignored.
// - Address and data pass through unmodified; line alignment is the caches' responsibility.
// CONFIGURATION
// - PMEM_ARB_ROUND_ROBIN_EN defined:
//   - On a simultaneous request, grant the requester not served last.
//   - The pointer updates on every entry to RESP.
// - Not defined:
//   - Fixed priority, D-cache always wins.
//   - The pointer register is not built.
// TESTING
// - I-only read @0x0000_1000, mem_resp after 4 cycles with 0xA5.. -> mem_read=1 with addr 0x1000 held; i_pmem_resp one cycle later; i_pmem_rdata=0xA5..; d_pmem_resp never 1.
// - D writeback @0x0000_2000 of 0x5A.. -> mem_write=1, mem_wdata=0x5A..; d_pmem_resp pulses once; i_pmem_rdata unchanged.
// - i_read and d_read both asserted in the same cycle, held, fixed priority -> D served first, then I. Round-robin build with last=D -> I first.
// - Inputs change while D_BUSY (d_pmem_addr toggled) -> mem_addr stays at the latched value until mem_resp.
// - rst_n=0 during I_BUSY -> next cycle mem_read=0, state IDLE, no i_pmem_resp; a fresh request after reset completes normally.
// - Back-to-back D requests with request held through RESP -> exactly one resp per transaction; no strobe in the RESP cycle.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Arbitrates the I-cache and D-cache line ports onto one 256-bit memory port, one transaction at a time.
// Define PMEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise the D-cache has fixed priority.
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_addr,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_addr,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

  state_t            state_q, state_d;
  logic              grant_d_q, grant_d_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;
  logic              i_req, d_req, pick_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // last_d_q remembers whether the D-cache was the last requester served
  logic last_d_q, last_d_d;
  assign pick_d = d_req & (~i_req | ~last_d_q);
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d_d   = grant_d_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_resp_d    = 1'b0;
    d_resp_d    = 1'b0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    last_d_d    = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant_d_d   = pick_d;
          addr_d      = pick_d ? d_pmem_addr : i_pmem_addr;
          wdata_d     = pick_d ? d_pmem_wdata : '0;
          // a read+write collision from the D-cache is treated as a write
          mem_write_d = pick_d & d_pmem_write;
          mem_read_d  = ~(pick_d & d_pmem_write);
          state_d     = pick_d ? D_BUSY : I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (grant_d_q) begin
            d_rdata_d = mem_rdata;
            d_resp_d  = 1'b1;
          end else begin
            i_rdata_d = mem_rdata;
            i_resp_d  = 1'b1;
          end
`ifdef PMEM_ARB_ROUND_ROBIN_EN
          last_d_d = grant_d_q;
`endif
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_d_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_d_q   <= grant_d_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_resp_q    <= i_resp_d;
      d_resp_q    <= d_resp_d;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign i_pmem_rdata = i_rdata_q;
  assign i_pmem_resp  = i_resp_q;
  assign d_pmem_rdata = d_rdata_q;
  assign d_pmem_resp  = d_resp_q;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: single reads/writes, collisions, input hold, reset abort, back-to-back.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_addr;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_addr;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int compared = 0;
  int mismatched = 0;

  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_5A = {32{8'h5A}};
  localparam logic [255:0] PAT_B1 = {32{8'hB1}};
  localparam logic [255:0] PAT_C2 = {32{8'hC2}};
  localparam logic [255:0] PAT_D3 = {32{8'hD3}};
  localparam logic [255:0] PAT_E4 = {32{8'hE4}};
  localparam logic [255:0] PAT_F5 = {32{8'hF5}};

  pmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_addr(i_pmem_addr),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_addr(d_pmem_addr), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  // Protocol invariants checked on every falling edge
  always @(negedge clk) begin
    assert (!(d_pmem_read && d_pmem_write)) else begin
      mismatched++;
      $error("[TB] FAIL d_rw_collision: observed read=1 write=1 required not both");
    end
    assert (!(mem_read && mem_write)) else begin
      mismatched++;
      $error("[TB] FAIL strobe_excl: observed mem_read=1 mem_write=1 required not both");
    end
    assert (!(i_pmem_resp && d_pmem_resp)) else begin
      mismatched++;
      $error("[TB] FAIL resp_excl: observed both resp=1 required not both");
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge; mem_resp is a one-cycle pulse
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
  endtask

  initial begin
    logic [255:0] first_data;
    logic [255:0] second_data;
    logic [31:0]  first_addr;
    logic [31:0]  second_addr;
    logic         d_first;

    rst_n = 1'b0;
    i_pmem_read = 1'b0; i_pmem_addr = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_addr = '0; d_pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_mem_read", 256'(mem_read), 256'(0));
    checkOutput("rst_mem_write", 256'(mem_write), 256'(0));
    checkOutput("rst_mem_addr", 256'(mem_addr), 256'(0));
    checkOutput("rst_i_rdata", i_pmem_rdata, 256'(0));
    checkOutput("rst_d_rdata", d_pmem_rdata, 256'(0));
    checkOutput("rst_resps", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
    rst_n = 1'b1;

    // I-cache read, memory answers four cycles after the strobe appears
    i_pmem_read = 1'b1; i_pmem_addr = 32'h0000_1000;
    applyStimulus();
    for (int k = 0; k < 4; k++) begin
      checkOutput("i_rd_strobe", 256'({mem_read, mem_write}), 256'(2'b10));
      checkOutput("i_rd_addr", 256'(mem_addr), 256'(32'h0000_1000));
      checkOutput("i_rd_noresp", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
      if (k < 3) applyStimulus();
    end
    mem_resp = 1'b1; mem_rdata = PAT_A5;
    applyStimulus();
    checkOutput("i_rd_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'(2'b10));
    checkOutput("i_rd_rdata", i_pmem_rdata, PAT_A5);
    checkOutput("i_rd_strobe_clr", 256'({mem_read, mem_write}), 256'(0));
    i_pmem_read = 1'b0;
    applyStimulus();
    checkOutput("i_rd_resp_once", 256'(i_pmem_resp), 256'(0));
    checkOutput("i_rd_rdata_hold", i_pmem_rdata, PAT_A5);

    // D writeback with the live address toggled while busy
    d_pmem_write = 1'b1; d_pmem_addr = 32'h0000_2000; d_pmem_wdata = PAT_5A;
    applyStimulus();
    checkOutput("d_wr_strobe", 256'({mem_read, mem_write}), 256'(2'b01));
    checkOutput("d_wr_addr", 256'(mem_addr), 256'(32'h0000_2000));
    checkOutput("d_wr_wdata", mem_wdata, PAT_5A);
    d_pmem_addr = 32'h0000_3000; d_pmem_wdata = PAT_F5;
    applyStimulus();
    checkOutput("d_wr_addr_held", 256'(mem_addr), 256'(32'h0000_2000));
    checkOutput("d_wr_wdata_held", mem_wdata, PAT_5A);
    checkOutput("d_wr_strobe_held", 256'({mem_read, mem_write}), 256'(2'b01));
    mem_resp = 1'b1; mem_rdata = '0;
    applyStimulus();
    checkOutput("d_wr_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'(2'b01));
    checkOutput("d_wr_i_rdata_kept", i_pmem_rdata, PAT_A5);
    checkOutput("d_wr_strobe_clr", 256'({mem_read, mem_write}), 256'(0));
    d_pmem_write = 1'b0;
    applyStimulus();
    checkOutput("d_wr_resp_once", 256'(d_pmem_resp), 256'(0));

    // Simultaneous reads; last served was D, so round-robin picks I and fixed priority picks D
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    d_first = 1'b0;
`else
    d_first = 1'b1;
`endif
    first_addr  = d_first ? 32'h0000_5000 : 32'h0000_4000;
    second_addr = d_first ? 32'h0000_4000 : 32'h0000_5000;
    first_data  = PAT_B1;
    second_data = PAT_C2;
    i_pmem_read = 1'b1; i_pmem_addr = 32'h0000_4000;
    d_pmem_read = 1'b1; d_pmem_addr = 32'h0000_5000;
    applyStimulus();
    checkOutput("sim_first_addr", 256'(mem_addr), 256'(first_addr));
    checkOutput("sim_first_strobe", 256'({mem_read, mem_write}), 256'(2'b10));
    mem_resp = 1'b1; mem_rdata = first_data;
    applyStimulus();
    checkOutput("sim_first_resp", 256'({i_pmem_resp, d_pmem_resp}), d_first ? 256'(2'b01) : 256'(2'b10));
    checkOutput("sim_first_rdata", d_first ? d_pmem_rdata : i_pmem_rdata, first_data);
    if (d_first) d_pmem_read = 1'b0; else i_pmem_read = 1'b0;
    applyStimulus();
    checkOutput("sim_idle_strobe", 256'({mem_read, mem_write}), 256'(0));
    applyStimulus();
    checkOutput("sim_second_addr", 256'(mem_addr), 256'(second_addr));
    checkOutput("sim_second_strobe", 256'({mem_read, mem_write}), 256'(2'b10));
    mem_resp = 1'b1; mem_rdata = second_data;
    applyStimulus();
    checkOutput("sim_second_resp", 256'({i_pmem_resp, d_pmem_resp}), d_first ? 256'(2'b10) : 256'(2'b01));
    checkOutput("sim_second_rdata", d_first ? i_pmem_rdata : d_pmem_rdata, second_data);
    checkOutput("sim_first_rdata_kept", d_first ? d_pmem_rdata : i_pmem_rdata, first_data);
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    applyStimulus();

    // mem_resp while idle must be ignored
    mem_resp = 1'b1; mem_rdata = PAT_F5;
    applyStimulus();
    checkOutput("idle_resp_ignored", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
    checkOutput("idle_rdata_kept", i_pmem_rdata, second_data & {256{d_first}} | first_data & {256{~d_first}});

    // Reset in the middle of an I-cache read, then a fresh read completes
    i_pmem_read = 1'b1; i_pmem_addr = 32'h0000_6000;
    applyStimulus();
    checkOutput("rst_mid_strobe", 256'(mem_read), 256'(1));
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    checkOutput("rst_mid_strobe_drop", 256'({mem_read, mem_write}), 256'(0));
    checkOutput("rst_mid_noresp", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
    checkOutput("rst_mid_rdata_clr", i_pmem_rdata, 256'(0));
    applyStimulus();
    checkOutput("rst_fresh_strobe", 256'({mem_read, mem_write}), 256'(2'b10));
    checkOutput("rst_fresh_addr", 256'(mem_addr), 256'(32'h0000_6000));
    mem_resp = 1'b1; mem_rdata = PAT_D3;
    applyStimulus();
    checkOutput("rst_fresh_resp", 256'(i_pmem_resp), 256'(1));
    checkOutput("rst_fresh_rdata", i_pmem_rdata, PAT_D3);
    i_pmem_read = 1'b0;
    applyStimulus();

    // Back-to-back D reads with the request held through RESP
    d_pmem_read = 1'b1; d_pmem_addr = 32'h0000_7000;
    applyStimulus();
    checkOutput("b2b_strobe1", 256'(mem_read), 256'(1));
    mem_resp = 1'b1; mem_rdata = PAT_E4;
    applyStimulus();
    checkOutput("b2b_resp1", 256'(d_pmem_resp), 256'(1));
    checkOutput("b2b_resp_nostrobe", 256'({mem_read, mem_write}), 256'(0));
    checkOutput("b2b_rdata1", d_pmem_rdata, PAT_E4);
    applyStimulus();
    checkOutput("b2b_idle_noresp", 256'(d_pmem_resp), 256'(0));
    checkOutput("b2b_idle_nostrobe", 256'({mem_read, mem_write}), 256'(0));
    applyStimulus();
    checkOutput("b2b_strobe2", 256'(mem_read), 256'(1));
    checkOutput("b2b_busy_noresp", 256'(d_pmem_resp), 256'(0));
    mem_resp = 1'b1; mem_rdata = PAT_F5;
    applyStimulus();
    checkOutput("b2b_resp2", 256'(d_pmem_resp), 256'(1));
    checkOutput("b2b_rdata2", d_pmem_rdata, PAT_F5);
    d_pmem_read = 1'b0;
    applyStimulus();
    checkOutput("b2b_resp2_once", 256'(d_pmem_resp), 256'(0));
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
